// File: rtl/digit_serial_adder.sv
// rtl/digit_serial_adder.sv - digit-serial add/subtract with valid/ready handshakes
// One DIGIT-wide ripple slice is reused over NDIG cycles, LSB digit first.
module digit_serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d, res_next;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DIGIT-1:0] slice_s;
    logic             slice_co;
    logic             msb_cin;
    logic             last;

    always_comb begin
        logic c;
        c       = carry_q;
        msb_cin = carry_q;
        slice_s = '0;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) msb_cin = c;
            slice_s[i] = a_q[i] ^ b_q[i] ^ c;
            c          = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
        end
        slice_co = c;
    end

    // New digit enters at the MSB end, so after NDIG shifts the result is aligned.
    assign res_next = WIDTH'({slice_s, res_q} >> DIGIT);
    assign last     = (cnt_q == CW'(NDIG - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                res_d   = res_next;
                carry_d = slice_co;
                cnt_d   = cnt_q + CW'(1);
                if (last) begin
                    sum_d   = res_next;
                    cout_d  = slice_co;
                    ovf_d   = msb_cin ^ slice_co;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// tb/tb_digit_serial_adder.sv - directed bench for digit_serial_adder at DIGIT 2, 1 and 8
module tb_digit_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] a, b;
    logic       sub;

    logic       ir [3];
    logic       ov [3];
    logic [7:0] sm [3];
    logic       co [3];
    logic       of [3];

    int vectors     = 0;
    int miscompares = 0;
    int dg [3]      = '{2, 1, 8};
    int lat_exp [3] = '{4, 8, 1};

    always #5 clk = ~clk;

    digit_serial_adder #(.WIDTH(8), .DIGIT(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b), .sub(sub),
        .out_valid(ov[0]), .out_ready(out_ready), .sum(sm[0]), .cout(co[0]), .ovf(of[0]));
    digit_serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b), .sub(sub),
        .out_valid(ov[1]), .out_ready(out_ready), .sum(sm[1]), .cout(co[1]), .ovf(of[1]));
    digit_serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b), .sub(sub),
        .out_valid(ov[2]), .out_ready(out_ready), .sum(sm[2]), .cout(co[2]), .ovf(of[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [7:0] av, input logic [7:0] bv, input logic sv);
        a = av; b = bv; sub = sv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Called just after an accept edge; holds out_ready low until every instance is done.
    task automatic wait_check(input string tag, input logic [7:0] es, input logic ec, input logic eo);
        int lat [3];
        lat = '{-1, -1, -1};
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            if (k == 1) chk({tag, " busy in_ready d2"}, 32'(ir[0]), 0);
            for (int j = 0; j < 3; j++)
                if (ov[j] && lat[j] < 0) lat[j] = k;
        end
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("%s lat d%0d", tag, dg[j]), 32'(lat[j]), 32'(lat_exp[j]));
            chk($sformatf("%s sum d%0d", tag, dg[j]), 32'(sm[j]), 32'(es));
            chk($sformatf("%s cout d%0d", tag, dg[j]), 32'(co[j]), 32'(ec));
            chk($sformatf("%s ovf d%0d", tag, dg[j]), 32'(of[j]), 32'(eo));
        end
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("%s idle out_valid d%0d", tag, dg[j]), 32'(ov[j]), 0);
            chk($sformatf("%s idle in_ready d%0d", tag, dg[j]), 32'(ir[j]), 1);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("rst in_ready d%0d", dg[j]), 32'(ir[j]), 1);
            chk($sformatf("rst out_valid d%0d", dg[j]), 32'(ov[j]), 0);
            chk($sformatf("rst sum d%0d", dg[j]), 32'(sm[j]), 0);
            chk($sformatf("rst cout d%0d", dg[j]), 32'(co[j]), 0);
            chk($sformatf("rst ovf d%0d", dg[j]), 32'(of[j]), 0);
        end
        rst_n = 1'b1;

        start(8'hFF, 8'h01, 1'b0); wait_check("ff+01", 8'h00, 1'b1, 1'b0); release_out("ff+01");
        start(8'h7F, 8'h01, 1'b0); wait_check("7f+01", 8'h80, 1'b0, 1'b1); release_out("7f+01");
        start(8'h05, 8'h07, 1'b1); wait_check("05-07", 8'hFE, 1'b0, 1'b0); release_out("05-07");
        start(8'h80, 8'h01, 1'b1); wait_check("80-01", 8'h7F, 1'b1, 1'b1); release_out("80-01");

        start(8'h3C, 8'h0F, 1'b0); wait_check("bp", 8'h4B, 1'b0, 1'b0);
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            a = 8'(c * 17 + 1); b = ~a; sub = c[0];
            @(posedge clk); #1;
            chk($sformatf("bp hold sum %0d", c), 32'(sm[0]), 32'h4B);
            chk($sformatf("bp hold cout %0d", c), 32'(co[0]), 0);
            chk($sformatf("bp hold ovf %0d", c), 32'(of[0]), 0);
            chk($sformatf("bp hold out_valid %0d", c), 32'(ov[0]), 1);
            chk($sformatf("bp hold in_ready %0d", c), 32'(ir[0]), 0);
        end
        a = 8'h10; b = 8'h20; sub = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp release in_ready", 32'(ir[0]), 1);
        chk("bp release out_valid", 32'(ov[0]), 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp accept in_ready", 32'(ir[0]), 0);
        wait_check("bp2", 8'h30, 1'b0, 1'b0); release_out("bp2");

        start(8'hFF, 8'hFF, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("midrst out_valid d%0d", dg[j]), 32'(ov[j]), 0);
            chk($sformatf("midrst in_ready d%0d", dg[j]), 32'(ir[j]), 1);
            chk($sformatf("midrst sum d%0d", dg[j]), 32'(sm[j]), 0);
            chk($sformatf("midrst cout d%0d", dg[j]), 32'(co[j]), 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        start(8'h12, 8'h34, 1'b0); wait_check("12+34", 8'h46, 1'b0, 1'b0); release_out("12+34");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
- Parametrised multi-cycle successor to the fixed-width ripple-carry adder.
- Adds or subtracts two WIDTH-bit operands using a DIGIT-bit ripple-carry slice (chain of full adders). The slice processes one digit per clock, LSB digit first, with a registered carry between digits.
- Uses valid/ready handshakes on input and output, so it can sit between pipeline stages in the datapath.
- Trades latency for area: one DIGIT-wide adder replaces a WIDTH-wide one.

Parameters:
- WIDTH, 8, operand and result width in bits. Must be >= 2.
- DIGIT, 2, bits processed per cycle. Must satisfy 1 <= DIGIT <= WIDTH and WIDTH % DIGIT == 0.
- Derived, not overridable: NDIG = WIDTH/DIGIT, the number of run cycles.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 = A+B, 1 = A-B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result modulo 2^WIDTH.
- cout  output  1  carry out of the MSB. In subtract mode, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; in_ready=1, out_valid=0, sum=0, cout=0, ovf=0. Digit counter and carry register are cleared. Any in-flight operation is discarded with no output.
- FSM states: IDLE, RUN, DONE.
- in_ready = (state==IDLE). out_valid = (state==DONE). Both are decoded from registered state only.
- IDLE: an edge with in_valid && in_ready accepts the operation:
  - capture a;
  - capture b, or ~b when sub=1;
  - carry register <= sub;
  - counter <= 0; go to RUN.
  - a, b and sub are sampled only at this accept edge.
- RUN, each edge:
  - add the DIGIT LSBs of the A and B shift registers plus the carry register through the ripple slice;
  - shift the digit result into the result register from the MSB end;
  - shift the operands right by DIGIT;
  - update the carry register; increment the counter.
- Last digit (counter==NDIG-1):
  - record cout = slice carry out;
  - record ovf = (carry into slice bit DIGIT-1) XOR (slice carry out);
  - go to DONE.
  - If DIGIT==1, the carry into the MSB is the carry register value.
- Latency: out_valid rises exactly NDIG cycles after the accept edge.
- DONE:
  - sum, cout and ovf are held stable while out_valid=1 and out_ready=0 (backpressure of any length);
  - an edge with out_ready=1 completes the transfer and returns to IDLE.
- Outputs after transfer: sum, cout and ovf keep their last value until the next operation completes. Only out_valid qualifies them.
- Throughput: no overlap between operations. Minimum issue period is NDIG+2 cycles (accept, NDIG run cycles, DONE).
- Ignored inputs:
  - in_valid is ignored outside IDLE;
  - out_ready is ignored outside DONE.
- Arithmetic: result = (A + (sub ? ~B : B) + sub) mod 2^WIDTH, identical to a WIDTH-bit ripple-carry adder/subtractor.
- Reset mid-RUN or mid-DONE: outputs take their reset values immediately (asynchronous). The first accept is possible on the first edge after rst_n deasserts.

Test Plan:
- WIDTH=8, DIGIT=2, A+B, a=8'hFF, b=8'h01 -> sum=8'h00, cout=1, ovf=0; out_valid rises 4 cycles after the accept edge.
- a=8'h7F, b=8'h01, sub=0 -> sum=8'h80, cout=0, ovf=1.
- Subtract, a=8'h05, b=8'h07 -> sum=8'hFE, cout=0, ovf=0.
- Subtract, a=8'h80, b=8'h01 -> sum=8'h7F, cout=1, ovf=1.
- Backpressure and ignored input:
  - hold out_ready=0 for 5 cycles in DONE, with in_valid=1 and changing a/b;
  - required: sum/cout/ovf stable, in_ready=0, no new accept;
  - out_ready=1 -> IDLE next cycle, then the new operands are accepted.
- Reset and configuration sweep:
  - assert rst_n=0 two cycles into RUN -> out_valid=0, in_ready=1, sum=0 immediately;
  - then 8'h12+8'h34 -> 8'h46;
  - repeat the first four scenarios with DIGIT=1 (latency 8) and DIGIT=8 (latency 1).
